// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock,
// WIDTH steps per product, result on hi/lo with a one-cycle done pulse.
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mult_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_ABORT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum_s;

  // Booth recoding of {Q[0], q(-1)}: 01 adds M, 10 subtracts M, else hold.
  function automatic logic [WIDTH:0] booth_add(input logic [1:0]     pair,
                                               input logic [WIDTH:0] acc,
                                               input logic [WIDTH:0] m);
    case (pair)
      2'b01:   booth_add = acc + m;
      2'b10:   booth_add = acc - m;
      default: booth_add = acc;
    endcase
  endfunction

  // Next-state, datapath step and registered output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum_s   = {(WIDTH+1){1'b0}};
    case (state_q)
      IDLE, DONE: begin
        if (mult_ctrl == CMD_START) begin
          m_d     = {op_a[WIDTH-1], op_a};
          a_d     = {(WIDTH+1){1'b0}};
          q_d     = op_b;
          qm1_d   = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (mult_ctrl == CMD_ABORT) begin
          state_d = IDLE;
        end else begin
          // Add/subtract, then arithmetic shift of {A, Q, q(-1)} by one.
          sum_s = booth_add({q_q[0], qm1_q}, a_q, m_q);
          a_d   = {sum_s[WIDTH], sum_s[WIDTH:1]};
          q_d   = {sum_s[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH - 1)) begin
            hi_d    = a_d[WIDTH-1:0];
            lo_d    = q_d;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= {(WIDTH+1){1'b0}};
      m_q     <= {(WIDTH+1){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      qm1_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult: product table plus hand-written sequences
// for ignored start, abort, asynchronous reset and back-to-back starts.
module tb_booth_mult;

  logic        clk;
  logic        reset;
  logic [1:0]  mult_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  booth_mult #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_ctrl (mult_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Present a start for one edge (E0); returns just after E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mult_ctrl = 2'b01;
    op_a = a;
    op_b = b;
    @(posedge clk);
    #1;
    mult_ctrl = 2'b00;
  endtask

  // Sample ncyc negedges after E0; negedge k lies between E0+k-1 and E0+k.
  task automatic observe(input int ncyc, input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                         output int busy_cnt, output int done_cnt, output int first_done,
                         output logic [31:0] cap_hi, output logic [31:0] cap_lo,
                         output logic hold_ok);
    busy_cnt = 0; done_cnt = 0; first_done = -1;
    cap_hi = 32'h0; cap_lo = 32'h0; hold_ok = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = k; cap_hi = hi; cap_lo = lo;
        end
      end
      if (k < 33 && (hi !== hold_hi || lo !== hold_lo)) hold_ok = 1'b0;
    end
  endtask

  initial begin
    int bc, dc, fd, k1, k2;
    logic [31:0] ch, cl, prev_hi, prev_lo;
    logic hok;

    vecs[0] = '{32'd3,        32'd4,        32'h00000000, 32'h0000000C};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[4] = '{32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[5] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[6] = '{32'hFFFFFFF9, 32'hFFFFFFF7, 32'h00000000, 32'h0000003F};
    vecs[7] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000};

    reset = 1'b0; mult_ctrl = 2'b00; op_a = 32'h0; op_b = 32'h0;
    #1;
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy_done", {62'h0, busy, done}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    prev_hi = 32'h0; prev_lo = 32'h0;
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      observe(34, prev_hi, prev_lo, bc, dc, fd, ch, cl, hok);
      chk($sformatf("v%0d_done_at", i), 64'(fd), 64'd33);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd32);
      chk($sformatf("v%0d_done_count", i), 64'(dc), 64'd1);
      chk($sformatf("v%0d_hi", i), {32'h0, ch}, {32'h0, vecs[i].exp_hi});
      chk($sformatf("v%0d_lo", i), {32'h0, cl}, {32'h0, vecs[i].exp_lo});
      chk($sformatf("v%0d_hold_in_run", i), {63'h0, hok}, 64'd1);
      prev_hi = vecs[i].exp_hi; prev_lo = vecs[i].exp_lo;
    end

    // Start while busy and operand churn must not disturb 5x6.
    start_op(32'd5, 32'd6);
    dc = 0; fd = -1; ch = 32'h0; cl = 32'h0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done) begin
        dc++;
        if (fd < 0) begin fd = k; ch = hi; cl = lo; end
      end
      if (k == 10) begin mult_ctrl = 2'b01; op_a = 32'd7; op_b = 32'd7; end
      else if (k == 11) mult_ctrl = 2'b00;
      else if (k > 11 && k < 30) begin op_a = $urandom; op_b = $urandom; end
    end
    chk("ign_done_at", 64'(fd), 64'd33);
    chk("ign_done_count", 64'(dc), 64'd1);
    chk("ign_result", {ch, cl}, 64'd30);

    // Abort after a completed 2x3.
    start_op(32'd2, 32'd3);
    observe(34, 32'h0, 32'd30, bc, dc, fd, ch, cl, hok);
    chk("pre_abort_lo", {ch, cl}, 64'd6);
    start_op(32'd9, 32'd9);
    dc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) dc++;
      if (k == 5) begin
        chk("abort_busy_before", {63'h0, busy}, 64'd1);
        mult_ctrl = 2'b10;
      end else if (k == 6) begin
        chk("abort_busy_after", {63'h0, busy}, 64'd0);
        mult_ctrl = 2'b00;
      end
    end
    chk("abort_no_done", 64'(dc), 64'd0);
    chk("abort_retained", {hi, lo}, 64'd6);
    start_op(32'd9, 32'd9);
    observe(34, 32'h0, 32'd6, bc, dc, fd, ch, cl, hok);
    chk("post_abort_result", {ch, cl}, 64'd81);

    // Asynchronous reset mid-run, then reserved command held in IDLE.
    start_op(32'd100, 32'd100);
    repeat (12) @(negedge clk);
    chk("rst_busy_before", {63'h0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_hilo", {hi, lo}, 64'h0);
    chk("rst_async_busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    mult_ctrl = 2'b11;
    bc = 0; dc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    mult_ctrl = 2'b00;
    chk("rsvd_no_busy", 64'(bc), 64'd0);
    chk("rsvd_no_done", 64'(dc), 64'd0);

    // Back-to-back: start accepted in the DONE cycle, sampled at E0+33.
    start_op(32'd2, 32'd2);
    dc = 0; k1 = -1; k2 = -1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (done) begin
        dc++;
        if (dc == 1) begin
          k1 = k;
          chk("b2b_first", {hi, lo}, 64'd4);
          mult_ctrl = 2'b01; op_a = 32'hFFFFFFFD; op_b = 32'd5;
        end else if (dc == 2) begin
          k2 = k;
          chk("b2b_second", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        end
      end
      if (k1 > 0 && k == k1 + 1) begin
        mult_ctrl = 2'b00;
        chk("b2b_busy_no_gap", {63'h0, busy}, 64'd1);
      end
    end
    chk("b2b_first_at", 64'(k1), 64'd33);
    chk("b2b_second_at", 64'(k2), 64'd66);
    chk("b2b_done_count", 64'(dc), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
